// File: rtl/conv_core_if.sv
// rtl/conv_core_if.sv - memory-side and control bus of the 1-D convolution core
interface conv_core_if #(
    parameter int DATAWIDTH = 32,
    parameter int XADDR_W   = 5,
    parameter int YADDR_W   = 5,
    parameter int ZADDR_W   = 6
);
    logic                 start;
    logic [DATAWIDTH-1:0] dconfig;
    logic [XADDR_W-1:0]   x_addr;
    logic [DATAWIDTH-1:0] x_data;
    logic [YADDR_W-1:0]   y_addr;
    logic [DATAWIDTH-1:0] y_data;
    logic                 z_we;
    logic [ZADDR_W-1:0]   z_addr;
    logic [DATAWIDTH-1:0] z_data;
    logic                 busy;
    logic                 done;

    modport master (
        output start, dconfig, x_data, y_data,
        input  x_addr, y_addr, z_we, z_addr, z_data, busy, done
    );

    modport slave (
        input  start, dconfig, x_data, y_data,
        output x_addr, y_addr, z_we, z_addr, z_data, busy, done
    );
endinterface

// File: rtl/conv_core.sv
// rtl/conv_core.sv - 1-D convolution sequencer and MAC datapath
module conv_core #(
    parameter int DATAWIDTH = 32,
    parameter int XADDR_W   = 5,
    parameter int YADDR_W   = 5,
    parameter int ZADDR_W   = 6
) (
    input  logic         clk,
    input  logic         rst_a,
    input  logic         en_s,
    conv_core_if.slave   bus
);
    typedef enum logic [2:0] {S_IDLE, S_CALC, S_DRAIN, S_WRITE, S_DONE} state_t;

    state_t               state, state_nx;
    logic [4:0]           size_x, size_y;
    logic [ZADDR_W-1:0]   i_r;
    logic [XADDR_W-1:0]   j_r;
    logic [YADDR_W-1:0]   yj_r;
    logic [DATAWIDTH-1:0] acc;
    logic                 rd_v;

    logic [ZADDR_W-1:0]   sx_z, sy_z, i_next, jlo_next, jhi_cur;
    logic [DATAWIDTH-1:0] prod;
    logic                 last_j, last_i, zero_size;
    logic                 unused_cfg;

    assign unused_cfg = &{1'b0, bus.dconfig[DATAWIDTH-1:10]};

    assign sx_z      = ZADDR_W'(size_x);
    assign sy_z      = ZADDR_W'(size_y);
    assign i_next    = i_r + ZADDR_W'(1);
    assign jlo_next  = (i_next >= sy_z) ? (i_next - sy_z + ZADDR_W'(1)) : '0;
    assign jhi_cur   = (i_r < sx_z) ? i_r : (sx_z - ZADDR_W'(1));
    assign last_j    = (ZADDR_W'(j_r) == jhi_cur);
    assign last_i    = (i_r == (sx_z + sy_z - ZADDR_W'(2)));
    assign zero_size = (bus.dconfig[4:0] == 5'd0) || (bus.dconfig[9:5] == 5'd0);
    // Truncating multiply: only the low DATAWIDTH bits ever reach the accumulator.
    assign prod      = bus.x_data * bus.y_data;

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state <= S_IDLE;
        end else if (en_s) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start) state_nx = zero_size ? S_DONE : S_CALC;
            S_CALC:  if (last_j) state_nx = S_DRAIN;
            S_DRAIN: state_nx = S_WRITE;
            S_WRITE: state_nx = last_i ? S_DONE : S_CALC;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // rd_v marks the cycle in which memory data for the previous issue is present.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            size_x <= '0;
            size_y <= '0;
            i_r    <= '0;
            j_r    <= '0;
            yj_r   <= '0;
            acc    <= '0;
            rd_v   <= 1'b0;
        end else if (en_s) begin
            rd_v <= (state == S_CALC);
            if (rd_v) begin
                acc <= acc + prod;
            end
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        size_x <= bus.dconfig[4:0];
                        size_y <= bus.dconfig[9:5];
                        i_r    <= '0;
                        j_r    <= '0;
                        yj_r   <= '0;
                        acc    <= '0;
                    end
                end
                S_CALC: begin
                    if (!last_j) begin
                        j_r  <= j_r + XADDR_W'(1);
                        yj_r <= yj_r - YADDR_W'(1);
                    end
                end
                S_WRITE: begin
                    if (!last_i) begin
                        i_r  <= i_next;
                        j_r  <= XADDR_W'(jlo_next);
                        yj_r <= YADDR_W'(i_next - jlo_next);
                        acc  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Addresses come straight from the index registers, so they hold outside CALC.
    assign bus.x_addr = j_r;
    assign bus.y_addr = yj_r;
    assign bus.z_we   = (state == S_WRITE);
    assign bus.z_addr = i_r;
    assign bus.z_data = acc;
    assign bus.done   = (state == S_DONE);
    assign bus.busy   = (state == S_CALC) || (state == S_DRAIN) || (state == S_WRITE);
endmodule

// File: tb/tb_conv_core.sv
// tb/tb_conv_core.sv - scoreboard bench for conv_core
module tb_conv_core;
    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic en_s = 1'b1;

    conv_core_if #(.DATAWIDTH(32), .XADDR_W(5), .YADDR_W(5), .ZADDR_W(6)) bus ();

    conv_core #(.DATAWIDTH(32), .XADDR_W(5), .YADDR_W(5), .ZADDR_W(6)) dut (
        .clk   (clk),
        .rst_a (rst_a),
        .en_s  (en_s),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] xmem [32];
    logic [31:0] ymem [32];
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) begin
        if (en_s) begin
            bus.x_data <= xmem[bus.x_addr];
            bus.y_data <= ymem[bus.y_addr];
        end
    end

    always @(negedge clk) begin
        if (rst_a && en_s && bus.z_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%h", bus.z_addr, bus.z_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.z_addr !== e.addr || bus.z_data !== e.data) begin
                    errors++;
                    $display("FAIL z_write got addr=%0d data=%h expected addr=%0d data=%h",
                             bus.z_addr, bus.z_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    task automatic push(input int a, input logic [31:0] d);
        wr_t e;
        e.addr = 6'(a);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic model(input int sx, input int sy);
        for (int i = 0; i <= sx + sy - 2; i++) begin
            logic [31:0] acc;
            acc = '0;
            for (int j = 0; j < sx; j++) begin
                if (i - j >= 0 && i - j < sy) begin
                    acc = acc + xmem[j] * ymem[i - j];
                end
            end
            push(i, acc);
        end
    endtask

    task automatic outs_zero(input string name);
        check(name, {39'd0, bus.x_addr, bus.y_addr, bus.z_we, bus.z_addr, bus.busy, bus.done},
              64'd0);
        check({name, "_zdata"}, {32'd0, bus.z_data}, 64'd0);
    endtask

    // mode: 0 plain, 1 second start at cycle 20, 2 en_s low cycles 30..34, 3 reset at cycle 25
    task automatic run(input string name, input int sx, input int sy, input int exp_lat,
                       input int mode);
        int lat;
        int dones;
        lat = 0;
        @(negedge clk);
        #2;
        bus.dconfig = 32'hFFFF_FC00 | 32'(sy << 5) | 32'(sx);
        bus.start   = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 300 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (bus.done) lat = c;
            #2;
            if (mode == 1 && c == 20) bus.start = 1'b1;
            if (mode == 1 && c == 21) bus.start = 1'b0;
            if (mode == 2 && c == 30) en_s = 1'b0;
            if (mode == 2 && c == 35) en_s = 1'b1;
            if (mode == 3 && c == 25) begin
                rst_a = 1'b0;
                #1;
                outs_zero({name, "_reset_outs"});
                check({name, "_pending"}, 64'(exp_q.size()), 64'd9);
                exp_q.delete();
                @(negedge clk);
                #2 rst_a = 1'b1;
                dones = 0;
                repeat (100) begin
                    @(negedge clk);
                    if (bus.done) dones++;
                end
                check({name, "_no_done"}, 64'(dones), 64'd0);
                return;
            end
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        @(negedge clk);
        check({name, "_idle_after"}, {62'd0, bus.busy, bus.done}, 64'd0);
        check({name, "_all_written"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.dconfig = '0;
        for (int k = 0; k < 32; k++) begin
            xmem[k] = '0;
            ymem[k] = '0;
        end
        #23;
        outs_zero("reset");
        @(negedge clk);
        rst_a = 1'b1;

        xmem[0] = 32'd3;
        ymem[0] = 32'd4;
        push(0, 32'h0000_000C);
        run("mac_1x1", 1, 1, 4, 0);

        xmem[0] = 32'hFFFF_FFFF;
        ymem[0] = 32'd2;
        push(0, 32'hFFFF_FFFE);
        run("wrap_1x1", 1, 1, 4, 0);

        xmem[0] = 32'd1; xmem[1] = 32'd1;
        ymem[0] = 32'd1; ymem[1] = 32'd1;
        push(0, 32'd1);
        push(1, 32'd2);
        push(2, 32'd1);
        run("ones_2x2", 2, 2, 11, 0);

        run("zero_x", 0, 5, 1, 0);
        run("zero_y", 5, 0, 1, 0);

        for (int k = 0; k < 10; k++) xmem[k] = $urandom;
        for (int k = 0; k < 5; k++) ymem[k] = $urandom;
        model(10, 5);
        run("conv_10x5", 10, 5, 79, 0);
        model(10, 5);
        run("restart_ignored", 10, 5, 79, 1);
        model(10, 5);
        run("enable_stall", 10, 5, 84, 2);
        model(10, 5);
        run("mid_reset", 10, 5, 0, 3);
        model(10, 5);
        run("after_reset", 10, 5, 79, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
